// File: rtl/tick_scheduler.sv
// Single-clock rate controller: a shared prescaler makes a base tick, and N_CH channels
// divide it by runtime-programmable divisors into one-cycle enable ticks.
module tick_scheduler #(
  parameter int PRESCALE = 50000,
  parameter int N_CH     = 4,
  parameter int DIV_W    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    run,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [$clog2(N_CH)-1:0] cfg_ch,
  input  logic [DIV_W-1:0]        cfg_div,
  output logic                    active,
  output logic                    base_tick,
  output logic [N_CH-1:0]         tick
);

  localparam int CH_W = $clog2(N_CH);
  localparam int P_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [P_W-1:0] P_LAST = P_W'(PRESCALE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   xfer;
  logic   e_base;

  logic [P_W-1:0]   p;
  logic [DIV_W-1:0] div_q [N_CH];
  logic [DIV_W-1:0] cnt_q [N_CH];
  logic [N_CH-1:0]  en_q;
  logic [N_CH-1:0]  wr_ch;
  logic [N_CH-1:0]  hit_ch;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // HOLD lasts exactly one cycle, which caps writes at one per two cycles.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_RUN: state_nxt = xfer ? S_HOLD : (run ? S_RUN : S_IDLE);
      S_HOLD:        state_nxt = run ? S_RUN : S_IDLE;
      default:       state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cfg_ready = (state != S_HOLD);
    xfer      = cfg_valid & cfg_ready;
  end

  assign e_base = active && (p == P_LAST);

  always_comb begin
    wr_ch  = '0;
    hit_ch = '0;
    for (int i = 0; i < N_CH; i++) begin
      wr_ch[i]  = xfer && (cfg_ch == CH_W'(i));
      hit_ch[i] = e_base && en_q[i] && (cnt_q[i] == div_q[i] - DIV_W'(1));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active    <= 1'b0;
      base_tick <= 1'b0;
      p         <= '0;
    end else begin
      active    <= run;
      base_tick <= e_base;
      if (!run)        p <= '0;
      else if (e_base) p <= '0;
      else if (active) p <= p + P_W'(1);
    end
  end

  // A configuration write wins over a same-cycle base event on its channel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_CH; i++) begin
        div_q[i] <= '0;
        cnt_q[i] <= '0;
      end
      en_q <= '0;
      tick <= '0;
    end else begin
      tick <= hit_ch & ~wr_ch;
      for (int i = 0; i < N_CH; i++) begin
        if (wr_ch[i]) begin
          div_q[i] <= cfg_div;
          en_q[i]  <= (cfg_div != '0);
        end
        if (!run || wr_ch[i])        cnt_q[i] <= '0;
        else if (hit_ch[i])          cnt_q[i] <= '0;
        else if (e_base && en_q[i])  cnt_q[i] <= cnt_q[i] + DIV_W'(1);
      end
    end
  end

endmodule
